muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 104 ++++++++++
 tb/tb_muldiv_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO controller with single-cycle multiply and 32-cycle restoring divide
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_cancel,
  output logic        req_ready,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      state;
  logic [31:0] opa, opb, quo, rem;
  logic [4:0]  cnt;
  logic        msign, qsign, rsign, dzero;
  logic        accept, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] trial;
  logic [31:0] quo_n, rem_n, mag1, mag2;
  // priority decode of the request, operand magnitudes and one restoring-division step
  always_comb begin
    req_ready = (state == IDLE) & ~req_cancel & ~reset;
    accept    = req_valid & req_ready;
    md_busy   = state != IDLE;
    md_done   = ~req_cancel & ((state == MUL) | ((state == DIV) & (dzero | (cnt == 5'd31))));
    op_mult   = req_op[7];
    op_multu  = ~req_op[7] & req_op[6];
    op_div    = ~|req_op[7:6] & req_op[5];
    op_divu   = ~|req_op[7:5] & req_op[4];
    op_mthi   = ~|req_op[7:4] & req_op[1];
    op_mtlo   = ~|req_op[7:4] & ~req_op[1] & req_op[0];
    op_mfhi   = ~|req_op[7:4] & ~|req_op[1:0] & req_op[3];
    op_mflo   = ~|req_op[7:4] & ~|req_op[1:0] & ~req_op[3] & req_op[2];
    mf_data   = (accept & op_mfhi) ? hi : (accept & op_mflo) ? lo : 32'd0;
    ext_a     = {{32{msign & opa[31]}}, opa};
    ext_b     = {{32{msign & opb[31]}}, opb};
    prod      = ext_a * ext_b;
    trial     = {rem, quo[31]} - {1'b0, opb};
    rem_n     = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
    quo_n     = {quo[30:0], ~trial[32]};
    mag1      = (op_div & req_src1[31]) ? -req_src1 : req_src1;
    mag2      = (op_div & req_src2[31]) ? -req_src2 : req_src2;
  end
  // controller FSM together with HI/LO and divider datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      opa   <= '0;
      opb   <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      msign <= 1'b0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      dzero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (op_mult | op_multu) begin
            opa   <= req_src1;
            opb   <= req_src2;
            msign <= op_mult;
            state <= MUL;
          end else if (op_div | op_divu) begin
            quo   <= mag1;
            opb   <= mag2;
            rem   <= '0;
            cnt   <= '0;
            qsign <= op_div & (req_src1[31] ^ req_src2[31]);
            rsign <= op_div & req_src1[31];
            dzero <= req_src2 == 32'd0;
            state <= DIV;
          end else if (op_mthi) hi <= req_src1;
          else if (op_mtlo) lo <= req_src1;
        end
        MUL: begin
          state <= IDLE;
          if (!req_cancel) {hi, lo} <= prod;
        end
        DIV: if (req_cancel | dzero) state <= IDLE;
        else begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            lo    <= qsign ? -quo_n : quo_n;
            hi    <= rsign ? -rem_n : rem_n;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl against an arithmetic HI/LO model
module tb_muldiv_ctrl;
  logic        clk = 1'b0, reset, req_valid, req_cancel;
  logic [7:0]  req_op;
  logic [31:0] req_src1, req_src2, mf_data, hi, lo;
  logic        req_ready, md_busy, md_done;
  int          errs = 0, checks = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_cancel(req_cancel),
    .req_ready(req_ready), .md_busy(md_busy), .md_done(md_done),
    .mf_data(mf_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo, 8 none
  function automatic int pick(input logic [7:0] op);
    int order[8] = '{7, 6, 5, 4, 1, 0, 3, 2};
    for (int i = 0; i < 8; i++) if (op[order[i]]) return i;
    return 8;
  endfunction

  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int k, n, cyc;
    logic [31:0] exp_mf;
    longint p, sa, sb, q, r;
    k = pick(op);
    exp_mf = (k == 6) ? m_hi : (k == 7) ? m_lo : 32'd0;
    cyc = (k < 2) ? 1 : (k < 4) ? ((b == 0) ? 1 : 32) : 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    #1;
    check("ready", {63'd0, req_ready}, 64'd1);
    check("mf_data", {32'd0, mf_data}, {32'd0, exp_mf});
    @(negedge clk);
    req_valid = 1'b0; req_op = 8'd0;
    n = 0;
    while (md_busy && n < 40) begin
      check("done", {63'd0, md_done}, {63'd0, n == cyc - 1});
      check("ready_busy", {63'd0, req_ready}, 64'd0);
      req_valid = 1'b1; req_op = 8'h03; req_src1 = $urandom;
      n++;
      @(negedge clk);
      req_valid = 1'b0; req_op = 8'd0;
    end
    check("busy_cycles", 64'(n), 64'(cyc));
    case (k)
      0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
      1: begin p = longint'(a) * longint'(b); {m_hi, m_lo} = p; end
      2: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      3: if (b != 0) begin
        sa = longint'(a); sb = longint'(b);
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      4: m_hi = a;
      5: m_lo = a;
      default: ;
    endcase
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    int sel;
    logic [7:0]  op;
    logic [31:0] b;
    reset = 1'b1; req_valid = 1'b0; req_cancel = 1'b0;
    req_op = 8'd0; req_src1 = 32'd0; req_src2 = 32'd0;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, md_busy}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    do_op(8'h80, 32'hFFFFFFFF, 32'h00000002);
    check("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("mult_lo", {32'd0, lo}, 64'hFFFFFFFE);
    do_op(8'h40, 32'hFFFFFFFF, 32'h00000002);
    check("multu_hi", {32'd0, hi}, 64'h00000001);
    check("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);
    do_op(8'h20, 32'hFFFFFFF9, 32'h00000002);
    check("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
    do_op(8'h04, 32'd0, 32'd0);
    do_op(8'h20, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo", {32'd0, lo}, 64'h80000000);
    check("ovf_hi", {32'd0, hi}, 64'h0);
    do_op(8'h02, 32'h12345678, 32'd0);
    do_op(8'h01, 32'h12345678, 32'd0);
    do_op(8'h10, 32'd100, 32'd0);
    check("dz_hi", {32'd0, hi}, 64'h12345678);
    check("dz_lo", {32'd0, lo}, 64'h12345678);

    @(negedge clk);
    req_valid = 1'b1; req_op = 8'h20; req_src1 = 32'd100; req_src2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; req_op = 8'd0;
    repeat (10) @(negedge clk);
    req_cancel = 1'b1;
    #1;
    check("cancel_done", {63'd0, md_done}, 64'd0);
    check("cancel_ready", {63'd0, req_ready}, 64'd0);
    check("cancel_busy", {63'd0, md_busy}, 64'd1);
    @(negedge clk);
    req_cancel = 1'b0;
    check("post_cancel_busy", {63'd0, md_busy}, 64'd0);
    check("post_cancel_hi", {32'd0, hi}, {32'd0, m_hi});
    check("post_cancel_lo", {32'd0, lo}, {32'd0, m_lo});
    do_op(8'h10, 32'd100, 32'd7);
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 8) ? 8'(1 << sel) : (sel == 8) ? 8'($urandom) : 8'd0;
      sel = $urandom_range(0, 5);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      do_op(op, $urandom, b);
    end

    @(negedge clk);
    req_valid = 1'b1; req_op = 8'h20; req_src1 = $urandom; req_src2 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0; req_op = 8'd0;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1; req_valid = 1'b1; req_op = 8'h08;
    #1;
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_busy", {63'd0, md_busy}, 64'd0);
    check("arst_done", {63'd0, md_done}, 64'd0);
    check("arst_ready", {63'd0, req_ready}, 64'd0);
    check("arst_mf", {32'd0, mf_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; req_op = 8'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    do_op(8'h08, 32'd0, 32'd0);
    do_op(8'h80, 32'd3, 32'hFFFFFFFB);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
